// File: rtl/aes_cbc_decrypt_ctrl.sv
// CBC decrypt wrapper around a combinational AES inverse cipher; plaintext appears SETTLE cycles after
// ciphertext acceptance, and s_ready drops for the whole block until m_ready retires the output.
module AES_Decrypt #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic [127:0] in,
  input  logic [N-1:0] key,
  output logic [127:0] out
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Field inverse as a^254, which also maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] st);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = st[127-32*c -: 8];
      a1 = st[119-32*c -: 8];
      a2 = st[111-32*c -: 8];
      a3 = st[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_cipher(input logic [127:0] ct, input logic [N-1:0] k);
    logic [31:0]  w [0:4*Nr+3];
    logic [N-1:0] kk;
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [0:15];
    logic [127:0] st;
    kk = k;
    for (int i = 0; i < Nk; i++) begin
      w[i] = kk[N-1 -: 32];
      kk   = kk << 32;
    end
    rc = 8'h01;
    for (int i = Nk; i < 4*Nr+4; i++) begin
      t = w[i-1];
      if (i % Nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (Nk > 6 && i % Nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-Nk] ^ t;
    end
    st = ct ^ {w[4*Nr], w[4*Nr+1], w[4*Nr+2], w[4*Nr+3]};
    for (int rnd = Nr - 1; rnd >= 0; rnd--) begin
      for (int i = 0; i < 16; i++) s[i] = st[127-8*i -: 8];
      // Row j rotates right by j; bytes are column-major in the 128-bit word.
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          st[127-8*(4*c+j) -: 8] = inv_sbox(s[4*((c-j+4)%4)+j]);
      st = st ^ {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
      if (rnd > 0) st = inv_mix(st);
    end
    return st;
  endfunction

  assign out = inv_cipher(in, key);

endmodule

module aes_cbc_decrypt_ctrl #(
  parameter int N      = 128,
  parameter int Nr     = 10,
  parameter int Nk     = 4,
  parameter int SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   key,
  input  logic           key_load,
  input  logic [127:0]   iv,
  input  logic           iv_load,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [127:0]   s_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [127:0]   m_data,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [N-1:0]   key_q, key_d;
  logic [127:0]   chain_q, chain_d;
  logic [127:0]   ct_q, ct_d;
  logic [127:0]   m_data_q, m_data_d;
  logic           m_valid_q, m_valid_d;
  logic [127:0]   aes_out;

  AES_Decrypt #(.N(N), .Nr(Nr), .Nk(Nk)) u_aes (
    .in  (ct_q),
    .key (key_q),
    .out (aes_out)
  );

  // Register loads take priority over block acceptance in IDLE.
  assign s_ready = rst_n && (state_q == IDLE) && !iv_load && !key_load;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    chain_d   = chain_q;
    ct_d      = ct_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    case (state_q)
      IDLE: begin
        if (key_load) key_d = key;
        if (iv_load)  chain_d = iv;
        if (s_valid && s_ready) begin
          ct_d    = s_data;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          m_data_d  = aes_out ^ chain_q;
          chain_d   = ct_q;
          m_valid_d = 1'b1;
          state_d   = OUT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      OUT: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      key_q     <= '0;
      chain_q   <= '0;
      ct_q      <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      chain_q   <= chain_d;
      ct_q      <= ct_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

endmodule
